// File: rtl/ex_mem_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_pipeline_register
// Brief   : EX/MEM pipeline register of the 16-bit MIPS with stall, flush,
//           registered branch resolution and a saturating taken-branch count.
// Revision: 1.0 - initial release
// ============================================================================
module ex_mem_pipeline_register #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] branch_target_in,
    input  logic              zero_in,
    input  logic [REG_W-1:0]  write_reg_in,
    input  logic [DATA_W-1:0] store_data_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              Branch_in,
    input  logic              cnt_clear,
    output logic              valid_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [DATA_W-1:0] branch_target_out,
    output logic [DATA_W-1:0] store_data_out,
    output logic              zero_out,
    output logic [REG_W-1:0]  write_reg_out,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic              MemRead_out,
    output logic              MemWrite_out,
    output logic              PCSrc,
    output logic [CNT_W-1:0]  branch_taken_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              r_valid;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_branch_target;
    logic [DATA_W-1:0] r_store_data;
    logic              r_zero;
    logic [REG_W-1:0]  r_write_reg;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_branch;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_capture;
    logic              w_taken_in;

    assign w_capture  = !flush && !stall;
    assign w_taken_in = valid_in && Branch_in && zero_in;

    // Flush inserts an all-zero bubble; stall simply leaves every register alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= 1'b0;
            r_alu_result    <= '0;
            r_branch_target <= '0;
            r_store_data    <= '0;
            r_zero          <= 1'b0;
            r_write_reg     <= '0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_branch        <= 1'b0;
        end else if (flush) begin
            r_valid         <= 1'b0;
            r_alu_result    <= '0;
            r_branch_target <= '0;
            r_store_data    <= '0;
            r_zero          <= 1'b0;
            r_write_reg     <= '0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_branch        <= 1'b0;
        end else if (!stall) begin
            r_valid         <= valid_in;
            r_alu_result    <= alu_result_in;
            r_branch_target <= branch_target_in;
            r_store_data    <= store_data_in;
            r_zero          <= zero_in;
            r_write_reg     <= write_reg_in;
            r_reg_write     <= RegWrite_in;
            r_mem_to_reg    <= MemtoReg_in;
            r_mem_read      <= MemRead_in;
            r_mem_write     <= MemWrite_in;
            r_branch        <= Branch_in;
        end
    end

    // Counts only on the capturing edge so a held instruction is counted once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= '0;
        end else if (cnt_clear) begin
            r_taken_cnt <= '0;
        end else if (w_capture && w_taken_in && (r_taken_cnt != c_cnt_max)) begin
            r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end

    assign valid_out         = r_valid;
    assign alu_result_out    = r_alu_result;
    assign branch_target_out = r_branch_target;
    assign store_data_out    = r_store_data;
    assign zero_out          = r_zero;
    assign write_reg_out     = r_write_reg;
    assign RegWrite_out      = r_reg_write  & r_valid;
    assign MemtoReg_out      = r_mem_to_reg & r_valid;
    assign MemRead_out       = r_mem_read   & r_valid;
    assign MemWrite_out      = r_mem_write  & r_valid;
    assign PCSrc             = r_branch & r_zero & r_valid;
    assign branch_taken_cnt  = r_taken_cnt;

endmodule
`default_nettype wire
